// File: rtl/haze_frame_ctrl.sv
// Frame sequencer for the dehaze pipeline: measures the dark-channel maximum per
// frame and updates atmospheric light and frame-constant parameters at frame end.
module haze_frame_ctrl #(
  parameter logic [10:0] IMG_HDISP = 11'd1024,
  parameter logic [10:0] IMG_VDISP = 11'd768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_dark,
  input  logic        cfg_enable,
  input  logic [7:0]  cfg_omega,
  input  logic [7:0]  cfg_a_min,
  input  logic        cfg_update,
  output logic        dehaze_en,
  output logic [7:0]  omega_active,
  output logic [7:0]  atmos_A,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, UPDATE} state_t;

  state_t      state_q, state_d;
  logic        vsync_q, href_q;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [7:0]  dark_max_q, dark_max_d;
  logic        line_err_q, line_err_d;
  logic        first_frame_q;
  logic        sh_enable_q;
  logic [7:0]  sh_omega_q, sh_a_min_q;
  logic        dehaze_en_q;
  logic [7:0]  omega_q, atmos_q;
  logic        frame_err_q;
  logic [15:0] frame_cnt_q;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  logic sof, eof, eol, pix_vld;
  assign sof     = per_frame_vsync & ~vsync_q;
  assign eof     = ~per_frame_vsync & vsync_q;
  assign eol     = ~per_frame_href & href_q;
  assign pix_vld = per_frame_clken & per_frame_href;

  // Frame-end arithmetic: IIR (3*A + max)/4 held in 10 bits, then a_min clamp
  logic       good, en_rise, load_direct;
  logic [9:0] iir_sum;
  logic [7:0] a_raw, a_new;
  assign good        = ~line_err_q && (line_cnt_q == IMG_VDISP);
  assign en_rise     = sh_enable_q & ~dehaze_en_q;
  assign load_direct = first_frame_q | en_rise;
  assign iir_sum     = ({2'b00, atmos_q} << 1) + {2'b00, atmos_q} + {2'b00, dark_max_q};
  assign a_raw       = load_direct ? dark_max_q : iir_sum[9:2];
  assign a_new       = max8(a_raw, sh_a_min_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = WAIT_SOF;
      WAIT_SOF: if (sof) state_d = ACTIVE;
      ACTIVE:   if (eof) state_d = UPDATE;
      UPDATE:   state_d = WAIT_SOF;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_done = (state_q == UPDATE);
  end

  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    dark_max_d = dark_max_q;
    line_err_d = line_err_q;
    if ((state_q == WAIT_SOF || state_q == ACTIVE) && sof) begin
      pix_cnt_d  = 11'd0;
      line_cnt_d = 11'd0;
      dark_max_d = 8'd0;
      line_err_d = 1'b0;
    end else if (state_q == ACTIVE) begin
      if (pix_vld) begin
        pix_cnt_d  = sat_inc11(pix_cnt_q);
        dark_max_d = max8(dark_max_q, per_img_dark);
      end
      if (eol) begin
        if (pix_cnt_q != IMG_HDISP) line_err_d = 1'b1;
        line_cnt_d = sat_inc11(line_cnt_q);
        pix_cnt_d  = 11'd0;
      end
    end
  end

  // Measurement stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      pix_cnt_q  <= 11'd0;
      line_cnt_q <= 11'd0;
      dark_max_q <= 8'd0;
      line_err_q <= 1'b0;
    end else begin
      vsync_q    <= per_frame_vsync;
      href_q     <= per_frame_href;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      dark_max_q <= dark_max_d;
      line_err_q <= line_err_d;
    end
  end

  // Shadow and frame-constant output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_enable_q   <= 1'b0;
      sh_omega_q    <= 8'd0;
      sh_a_min_q    <= 8'd0;
      first_frame_q <= 1'b1;
      dehaze_en_q   <= 1'b0;
      omega_q       <= 8'd0;
      atmos_q       <= 8'd255;
      frame_cnt_q   <= 16'd0;
      frame_err_q   <= 1'b0;
    end else begin
      if (cfg_update) begin
        sh_enable_q <= cfg_enable;
        sh_omega_q  <= cfg_omega;
        sh_a_min_q  <= cfg_a_min;
      end
      if (state_q == UPDATE) begin
        dehaze_en_q <= sh_enable_q;
        omega_q     <= sh_omega_q;
        if (good) begin
          atmos_q       <= a_new;
          first_frame_q <= 1'b0;
          frame_cnt_q   <= frame_cnt_q + 16'd1;
        end else if (en_rise) begin
          first_frame_q <= 1'b1;
        end
      end
      if ((state_q == UPDATE && !good) || (state_q == ACTIVE && sof))
        frame_err_q <= 1'b1;
      else if (cfg_update)
        frame_err_q <= 1'b0;
    end
  end

  assign dehaze_en    = dehaze_en_q;
  assign omega_active = omega_q;
  assign atmos_A      = atmos_q;
  assign frame_err    = frame_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_haze_frame_ctrl.sv
// Bench for haze_frame_ctrl on an 8x4 frame: directed scenarios plus randomized
// frames checked against a frame-level model of the A/enable/omega rules.
module tb_haze_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
  logic [7:0]  per_img_dark = 8'd0;
  logic        cfg_enable = 1'b0, cfg_update = 1'b0;
  logic [7:0]  cfg_omega = 8'd0, cfg_a_min = 8'd0;
  logic        dehaze_en, frame_done, frame_err;
  logic [7:0]  omega_active, atmos_A;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Frame-level reference state
  int m_A, m_en, m_omega, m_err, m_cnt, m_first;
  int m_sh_en, m_sh_omega, m_sh_amin;

  haze_frame_ctrl #(.IMG_HDISP(11'd8), .IMG_VDISP(11'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_dark(per_img_dark),
    .cfg_enable(cfg_enable), .cfg_omega(cfg_omega), .cfg_a_min(cfg_a_min),
    .cfg_update(cfg_update),
    .dehaze_en(dehaze_en), .omega_active(omega_active), .atmos_A(atmos_A),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_A = 255; m_en = 0; m_omega = 0; m_err = 0; m_cnt = 0; m_first = 1;
    m_sh_en = 0; m_sh_omega = 0; m_sh_amin = 0;
  endtask

  task automatic model_frame_end(input bit good, input int mx);
    bit rise;
    int raw;
    rise = (m_sh_en != 0) && (m_en == 0);
    if (good) begin
      raw     = (m_first != 0 || rise) ? mx : (3 * m_A + mx) / 4;
      m_A     = (raw < m_sh_amin) ? m_sh_amin : raw;
      m_first = 0;
      m_cnt   = (m_cnt + 1) % 65536;
    end else begin
      m_err = 1;
      if (rise) m_first = 1;
    end
    m_en    = m_sh_en;
    m_omega = m_sh_omega;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},    32'(dehaze_en), 0);
    chk({tag, "_omega"}, 32'(omega_active), 0);
    chk({tag, "_A"},     32'(atmos_A), 255);
    chk({tag, "_done"},  32'(frame_done), 0);
    chk({tag, "_err"},   32'(frame_err), 0);
    chk({tag, "_cnt"},   32'(frame_cnt), 0);
  endtask

  task automatic do_cfg(input int en, input int om, input int amin);
    cfg_enable = en[0]; cfg_omega = 8'(om); cfg_a_min = 8'(amin); cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
    @(negedge clk);
    m_sh_en = en; m_sh_omega = om; m_sh_amin = amin; m_err = 0;
  endtask

  task automatic drive_line(input int np, input bit rnd, input int vmax, input bit spike,
                            inout int mx);
    int n;
    n = 0;
    per_frame_href = 1'b1;
    while (n < np) begin
      per_frame_clken = ($urandom_range(0, 3) != 0);
      if (!per_frame_clken)      per_img_dark = 8'($urandom);
      else if (rnd)              per_img_dark = 8'($urandom_range(0, vmax));
      else if (spike && n == np - 1) per_img_dark = 8'(vmax);
      else                       per_img_dark = 8'(vmax / 2);
      @(negedge clk);
      if (per_frame_clken) begin
        if (int'(per_img_dark) > mx) mx = int'(per_img_dark);
        n++;
      end
    end
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame_count(output int pulses, input int hold_omega);
    per_frame_vsync = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (frame_done) begin
        pulses++;
        chk("omega_hold_at_done", 32'(omega_active), 32'(hold_omega));
      end
    end
  endtask

  task automatic run_frame(input int nl, input int short_ln, input bit rnd, input int vmax,
                           input int mid_omega);
    int mx, pulses, old_omega;
    bit good;
    mx = 0;
    per_frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    for (int l = 0; l < nl; l++) begin
      if (l == 1 && mid_omega >= 0) begin
        do_cfg(m_sh_en, mid_omega, m_sh_amin);
        chk("omega_mid_frame", 32'(omega_active), 32'(m_omega));
      end
      drive_line((l == short_ln) ? 7 : 8, rnd, vmax, (l == nl - 1), mx);
    end
    good = (nl == 4) && (short_ln < 0 || short_ln >= nl);
    old_omega = m_omega;
    end_frame_count(pulses, old_omega);
    model_frame_end(good, mx);
    chk("done_pulses", 32'(pulses), 1);
    chk("atmos_A",   32'(atmos_A), 32'(m_A));
    chk("dehaze_en", 32'(dehaze_en), 32'(m_en));
    chk("omega",     32'(omega_active), 32'(m_omega));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  initial begin
    int mx, pulses;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");

    // Scenario 1: first frame loads A directly
    do_cfg(1, 240, 100);
    run_frame(4, -1, 1'b0, 200, -1);
    chk("t1_A", 32'(atmos_A), 200);
    chk("t1_cnt", 32'(frame_cnt), 1);

    // Scenario 2: IIR smoothing
    run_frame(4, -1, 1'b0, 120, -1);
    chk("t2_A180", 32'(atmos_A), 180);
    run_frame(4, -1, 1'b0, 20, -1);
    chk("t2_A140", 32'(atmos_A), 140);

    // Scenario 3: a_min clamp
    do_cfg(1, 240, 160);
    run_frame(4, -1, 1'b0, 40, -1);
    chk("t3_A160", 32'(atmos_A), 160);

    // Scenario 4: geometry errors hold A and count, cfg_update clears
    run_frame(4, 2, 1'b0, 250, -1);
    chk("t4_A_held", 32'(atmos_A), 160);
    do_cfg(1, 240, 160);
    chk("t4_err_clr", 32'(frame_err), 0);
    run_frame(3, -1, 1'b0, 250, -1);
    chk("t4_cnt_held", 32'(frame_cnt), 4);
    do_cfg(1, 240, 160);
    chk("t4_err_clr2", 32'(frame_err), 0);

    // Scenario 5: omega change mid-frame applies only at frame end
    run_frame(4, -1, 1'b0, 180, 128);
    chk("t5_omega_new", 32'(omega_active), 128);

    // Randomized frames and configuration changes
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1)
        do_cfg(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 255), $urandom_range(0, 120));
      run_frame(($urandom_range(0, 5) == 0) ? 3 : 4, (k == 4) ? 1 : -1, 1'b1,
                $urandom_range(0, 255), -1);
    end

    // Scenario 6: reset mid-frame, partial frame ignored, next frame loads A directly
    mx = 0;
    per_frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    drive_line(8, 1'b1, 255, 1'b0, mx);
    per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_dark = 8'd250;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset("midrst");
    per_frame_href = 1'b0; per_frame_clken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_line(8, 1'b1, 255, 1'b0, mx);
    drive_line(8, 1'b1, 255, 1'b0, mx);
    end_frame_count(pulses, 0);
    chk("partial_no_done", 32'(pulses), 0);
    chk_reset("after_partial");
    do_cfg(1, 200, 30);
    run_frame(4, -1, 1'b1, 90, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
